// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined adder-tree population count with valid/ready flow control.
// Define POPCOUNT_ACCUM_EN to add a saturating per-group running sum (out_acc) on the output stage.

module popcount_add #(
  parameter int N         = 1,
  parameter int IMPL_TYPE = 0
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   sum_o
);
  if (IMPL_TYPE == 1) begin : g_ripple
    logic [N:0] c_s;
    always_comb begin
      c_s   = '0;
      sum_o = '0;
      for (int i = 0; i < N; i++) begin
        sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
        c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
      end
      sum_o[N] = c_s[N];
    end
  end else begin : g_behav
    assign sum_o = {1'b0, a_i} + {1'b0, b_i};
  end
endmodule

module popcount_pipe #(
  parameter int WIDTH        = 64,
  parameter int STAGE_LEVELS = 2,
  parameter int ACC_W        = 16,
  parameter int IMPL_TYPE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_count,
  output logic                     out_last
`ifdef POPCOUNT_ACCUM_EN
  ,
  output logic [ACC_W-1:0]         out_acc
`endif
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTAGE = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;

  logic              adv_s;
  logic [NSTAGE-1:0] vld_q, vld_d, last_q, last_d;

  assign adv_s     = ~vld_q[NSTAGE-1] | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = vld_q[NSTAGE-1];
  assign out_last  = last_q[NSTAGE-1];

  always_comb begin
    vld_d     = vld_q;
    last_d    = last_q;
    vld_d[0]  = in_valid;
    last_d[0] = in_last;
    for (int s = 1; s < NSTAGE; s++) begin
      vld_d[s]  = vld_q[s-1];
      last_d[s] = last_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv_s) begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Level k pairs k-bit sums from level k-1 into (k+1)-bit sums; registered at stage boundaries.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int  NODES = WIDTH >> k;
    localparam bit  REG   = ((k % STAGE_LEVELS) == 0) || (k == LEVELS);
    for (genvar j = 0; j < NODES; j++) begin : g_node
      logic [k:0] sum_d;
      logic [k:0] res_s;
      if (k == 1) begin : g_ha
        popcount_add #(.N(1), .IMPL_TYPE(IMPL_TYPE)) u_add (
          .a_i   (in_data[2*j]),
          .b_i   (in_data[2*j+1]),
          .sum_o (sum_d)
        );
      end else begin : g_add
        popcount_add #(.N(k), .IMPL_TYPE(IMPL_TYPE)) u_add (
          .a_i   (g_lvl[k-1].g_node[2*j].res_s),
          .b_i   (g_lvl[k-1].g_node[2*j+1].res_s),
          .sum_o (sum_d)
        );
      end
      if (REG) begin : g_reg
        logic [k:0] sum_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sum_q <= '0;
          end else if (adv_s) begin
            sum_q <= sum_d;
          end
        end
        assign res_s = sum_q;
      end else begin : g_comb
        assign res_s = sum_d;
      end
    end
  end

  assign out_count = g_lvl[LEVELS].g_node[0].res_s;

`ifdef POPCOUNT_ACCUM_EN
  localparam int CW = LEVELS + 1;
  localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;

  logic [ACC_W-1:0] acc_q, acc_d, base_s;
  logic             grp_new_q, grp_new_d;
  logic [SW-1:0]    sum_s;
  logic [CW-1:0]    cnt_s;

  assign cnt_s   = g_lvl[LEVELS].g_node[0].sum_d;
  assign out_acc = acc_q;

  // The word being loaded starts a new group if the last transferred word closed one.
  always_comb begin
    if (out_valid && out_ready) begin
      grp_new_d = out_last;
    end else begin
      grp_new_d = grp_new_q;
    end
    base_s = grp_new_d ? '0 : acc_q;
    sum_s  = SW'(base_s) + SW'(cnt_s);
    if (sum_s[SW-1:ACC_W] != '0) begin
      acc_d = '1;
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      grp_new_q <= 1'b1;
    end else begin
      grp_new_q <= grp_new_d;
      if (adv_s && vld_d[NSTAGE-1]) begin
        acc_q <= acc_d;
      end
    end
  end
`endif
endmodule

// File: tb/tb_popcount_pipe.sv
// Scoreboard bench for popcount_pipe (WIDTH=64, STAGE_LEVELS=2): directed latency/extreme/
// backpressure/reset cases plus a randomized stream; out_acc is checked when POPCOUNT_ACCUM_EN is defined.
module tb_popcount_pipe;
  localparam int WIDTH  = 64;
  localparam int SL     = 2;
  localparam int NSTAGE = 3;
  localparam int CW     = 7;
  localparam int ACC_W  = 8;

  typedef struct packed {
    logic          last;
    logic [CW-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_count;
  logic             out_last;
`ifdef POPCOUNT_ACCUM_EN
  logic [ACC_W-1:0] out_acc;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   stall_prev = 1'b0;
  logic [CW-1:0] hold_cnt;
  logic          hold_last;
  int   acc_m = 0;
  bit   grp_new = 1'b1;
  bit   rand_done;

  popcount_pipe #(.WIDTH(WIDTH), .STAGE_LEVELS(SL), .ACC_W(ACC_W), .IMPL_TYPE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_last  (out_last)
`ifdef POPCOUNT_ACCUM_EN
    ,
    .out_acc   (out_acc)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: sample at the falling edge; push accepted inputs, pop and compare transferred outputs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
      acc_m      = 0;
      grp_new    = 1'b1;
    end else begin
      if (stall_prev && out_valid) begin
        checks++;
        if (out_count !== hold_cnt || out_last !== hold_last) begin
          errors++;
          $display("FAIL hold_stable count=%0d last=%0b required count=%0d last=%0b",
                   out_count, out_last, hold_cnt, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output count=%0d required no output", out_count);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_count !== e.cnt || out_last !== e.last) begin
            errors++;
            $display("FAIL sb_count count=%0d last=%0b required count=%0d last=%0b",
                     out_count, out_last, e.cnt, e.last);
          end
`ifdef POPCOUNT_ACCUM_EN
          acc_m = (grp_new ? 0 : acc_m) + int'(e.cnt);
          if (acc_m > (1 << ACC_W) - 1) acc_m = (1 << ACC_W) - 1;
          grp_new = e.last;
          checks++;
          if (int'(out_acc) != acc_m) begin
            errors++;
            $display("FAIL sb_acc acc=%0d required %0d", out_acc, acc_m);
          end
`endif
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_cnt   = out_count;
      hold_last  = out_last;
      if (in_valid && in_ready) begin
        q.push_back('{last: in_last, cnt: CW'($countones(in_data))});
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout in_ready=0 required 1");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_async out_valid=%0b in_ready=%0b count=%0d required 0 1 0",
               out_valid, in_ready, out_count);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ones_word(input int n);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = 1'b1;
    return w;
  endfunction

  initial begin
    int lat;
    int n;
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [CW-1:0] exp3 [3];
    // Reset state
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out_valid=%0b in_ready=%0b count=%0d last=%0b required 0 1 0 0",
               out_valid, in_ready, out_count, out_last);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency from acceptance to out_valid
    send(64'h0F0F_0000_0000_00FF, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != NSTAGE || out_count !== 7'd16) begin
      errors++;
      $display("FAIL latency cycles=%0d count=%0d required %0d and 16", lat, out_count, NSTAGE);
    end
    idle(4);

    // Extremes back-to-back
    exp3[0] = 7'd0;
    exp3[1] = 7'd64;
    exp3[2] = 7'd2;
    send(64'h0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h8000_0000_0000_0001, 1'b1);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_count !== exp3[i]) begin
        errors++;
        $display("FAIL extremes[%0d] valid=%0b count=%0d required 1 %0d", i, out_valid, out_count, exp3[i]);
      end
    end
    drain();

    // Backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'(i == 7));
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (in_ready !== !out_valid) begin
            errors++;
            $display("FAIL backpressure in_ready=%0b required %0b", in_ready, !out_valid);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with words in flight
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b1);
    in_valid = 1'b0;
    do_reset();
    idle(8);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush pending=%0d out_valid=%0b required 0 0", q.size(), out_valid);
    end

    // Randomized stream with random gaps and output backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [WIDTH-1:0] w;
          w = {$urandom, $urandom};
          case ($urandom_range(0, 3))
            0: w = w & {$urandom, $urandom};
            1: w = w | {$urandom, $urandom};
            default: ;
          endcase
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(w, 1'($urandom_range(0, 3) == 0));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef POPCOUNT_ACCUM_EN
    // Group accumulation and saturation
    do_reset();
    send(ones_word(10), 1'b0);
    send(ones_word(20), 1'b0);
    send(ones_word(30), 1'b1);
    send(ones_word(5), 1'b0);
    for (int i = 0; i < 5; i++) send(ones_word(64), 1'b0);
    in_valid = 1'b0;
    drain();
    checks++;
    if (out_acc !== 8'd255) begin
      errors++;
      $display("FAIL acc_saturate acc=%0d required 255", out_acc);
    end
`endif

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
